// File: rtl/dtree_feeder_pkg.sv
// Shared definitions for the decision-tree feeder.
// Holds the FSM state encoding, the default feature/class geometry and the
// width of the accepted-result counter.
package dtree_feeder_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,  // accepting feature beats into the staging buffer
        ST_DRAIN = 2'd1,  // overlong sample: swallow beats until s_last
        ST_EVAL  = 2'd2,  // waiting out the classifier latency
        ST_OUT   = 2'd3   // result presented, waiting for m_ready
    } state_t;

    localparam int DEF_N_FEAT = 9;
    localparam int DEF_FEAT_W = 8;
    localparam int DEF_CLS_W  = 2;
    localparam int CNT_W      = 16;

endpackage

// File: rtl/dtree_feeder.sv
// Decision-tree feeder: collects N_FEAT feature beats from a valid/ready
// stream, presents the assembled vector to an external classifier and returns
// the registered class on a valid/ready result port.
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   s_valid/s_ready      feature beat handshake
//   s_data, s_last       feature value (X0 first), end-of-sample marker
//   feat                 assembled vector to the classifier, X0 in the LSBs
//   cls_in               classifier result for feat
//   m_valid/m_ready      result handshake
//   m_class, m_err       class result; m_err flags a malformed sample
//   sample_cnt           results accepted downstream, saturating
module dtree_feeder
    import dtree_feeder_pkg::*;
#(
    parameter int N_FEAT  = DEF_N_FEAT,
    parameter int FEAT_W  = DEF_FEAT_W,
    parameter int CLS_W   = DEF_CLS_W,
    parameter int CLS_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat,
    input  logic [CLS_W-1:0]         cls_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     m_err,
    output logic [CNT_W-1:0]         sample_cnt
);

    localparam int IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int WAIT_W = (CLS_LAT > 0) ? $clog2(CLS_LAT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    state_t                         state, nxt;
    logic [IDX_W-1:0]               idx;
    logic                           err_flag;
    logic [WAIT_W-1:0]              wait_q;
    // Beats land in a staging buffer; feat only updates when a sample
    // completes cleanly, so a malformed sample never disturbs the classifier
    // input left by the previous good one.
    logic [N_FEAT-1:0][FEAT_W-1:0]  buf_q;
    logic [N_FEAT*FEAT_W-1:0]       feat_q;

    logic beat;
    assign beat = s_valid && s_ready;
    assign feat = feat_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            ST_LOAD: begin
                if (beat) begin
                    if (s_last)                nxt = (idx == LAST_IDX) ? ST_EVAL : ST_OUT;
                    else if (idx == LAST_IDX)  nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (beat && s_last)      nxt = ST_OUT;
            ST_EVAL:  if (wait_q == '0)        nxt = ST_OUT;
            ST_OUT:   if (m_ready)             nxt = ST_LOAD;
            default:                           nxt = ST_LOAD;
        endcase
    end

    // FSM outputs
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        case (state)
            ST_LOAD, ST_DRAIN: s_ready = 1'b1;
            ST_OUT:            m_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            err_flag   <= 1'b0;
            wait_q     <= '0;
            buf_q      <= '0;
            feat_q     <= '0;
            m_class    <= '0;
            m_err      <= 1'b0;
            sample_cnt <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        buf_q[idx] <= s_data;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (s_last) begin
                                // last slot comes straight from s_data so feat
                                // is complete on EVAL entry
                                feat_q <= {s_data, buf_q[N_FEAT-2:0]};
                                wait_q <= WAIT_W'(CLS_LAT);
                            end else begin
                                err_flag <= 1'b1;
                            end
                        end else if (s_last) begin
                            idx      <= '0;
                            err_flag <= 1'b1;
                            m_err    <= 1'b1;
                            m_class  <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (beat && s_last) begin
                        m_err   <= 1'b1;
                        m_class <= '0;
                    end
                end
                ST_EVAL: begin
                    if (wait_q == '0) begin
                        m_class <= cls_in;
                        m_err   <= 1'b0;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        err_flag <= 1'b0;
                        if (sample_cnt != '1) sample_cnt <= sample_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_feeder.sv
module tb_dtree_feeder;
    localparam int NF = 9;
    localparam int FW = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic [FW-1:0] s_data  = '0;
    logic          m_ready = 1'b0;
    logic          use3    = 1'b0;

    logic             s_ready0, m_valid0, m_err0;
    logic [NF*FW-1:0] feat0;
    logic [CW-1:0]    cls0, m_class0;
    logic [15:0]      cnt0;

    logic             s_ready3, m_valid3, m_err3;
    logic [NF*FW-1:0] feat3;
    logic [CW-1:0]    cls3, m_class3;
    logic [15:0]      cnt3;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    // Stand-in classifier: low two bits of X0 xor low two bits of X1
    function automatic logic [CW-1:0] clsf(input logic [NF*FW-1:0] f);
        return f[1:0] ^ f[9:8];
    endfunction

    assign cls0 = clsf(feat0);
    assign cls3 = clsf(feat3);

    dtree_feeder #(.N_FEAT(NF), .FEAT_W(FW), .CLS_W(CW), .CLS_LAT(0)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid && !use3), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
        .feat(feat0), .cls_in(cls0),
        .m_valid(m_valid0), .m_ready(m_ready && !use3), .m_class(m_class0), .m_err(m_err0),
        .sample_cnt(cnt0)
    );

    dtree_feeder #(.N_FEAT(NF), .FEAT_W(FW), .CLS_W(CW), .CLS_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid && use3), .s_ready(s_ready3), .s_data(s_data), .s_last(s_last),
        .feat(feat3), .cls_in(cls3),
        .m_valid(m_valid3), .m_ready(m_ready && use3), .m_class(m_class3), .m_err(m_err3),
        .sample_cnt(cnt3)
    );

    logic             a_sready, a_mvalid, a_merr;
    logic [CW-1:0]    a_mclass;
    logic [NF*FW-1:0] a_feat;
    logic [15:0]      a_cnt;
    assign a_sready = use3 ? s_ready3 : s_ready0;
    assign a_mvalid = use3 ? m_valid3 : m_valid0;
    assign a_merr   = use3 ? m_err3   : m_err0;
    assign a_mclass = use3 ? m_class3 : m_class0;
    assign a_feat   = use3 ? feat3    : feat0;
    assign a_cnt    = use3 ? cnt3     : cnt0;

    logic [7:0] smp_a [NF] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    logic [7:0] smp_b [NF] = '{8'h03, 8'h05, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] smp_c [NF] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9};

    localparam logic [NF*FW-1:0] FEAT_A = 72'h181716151413121110;
    localparam logic [NF*FW-1:0] FEAT_B = 72'h887766554433220503;
    localparam logic [NF*FW-1:0] FEAT_C = 72'hC9C8C7C6C5C4C3C2C1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One beat; waits (bounded) for s_ready, accepted on the following posedge
    task automatic beat(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        while (!a_sready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a_sready) chk("sready_timeout", 0, 1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1 s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send9(input logic [7:0] b [NF]);
        for (int i = 0; i < NF; i++) beat(b[i], i == NF - 1);
    endtask

    // Cycles from the last accepted beat until m_valid is seen
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!a_mvalid && cyc < 40);
        if (!a_mvalid) chk("mvalid_timeout", 0, 1);
    endtask

    task automatic take();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        @(negedge clk);
        chk("sready_after_take", a_sready, 1);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_sready", a_sready, 1);
        chk("rst_mvalid", a_mvalid, 0);
        chk("rst_feat", a_feat, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_merr", a_merr, 0);
        chk("rst_mclass", a_mclass, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("sready_first", a_sready, 1);

        // good sample A, then hold result for 5 cycles
        send9(smp_a);
        wait_valid(lat);
        chk("a_lat", lat, 2);
        chk("a_feat", a_feat, FEAT_A);
        chk("a_class", a_mclass, 2'd1);
        chk("a_err", a_merr, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_sready", a_sready, 0);
            chk("hold_mvalid", a_mvalid, 1);
            chk("hold_class", a_mclass, 2'd1);
            chk("hold_err", a_merr, 0);
        end
        take();
        chk("a_cnt", a_cnt, 1);

        // short sample: s_last on 4th beat
        for (int i = 0; i < 4; i++) beat(8'h20 + 8'(i), i == 3);
        wait_valid(lat);
        chk("short_lat", lat, 1);
        chk("short_err", a_merr, 1);
        chk("short_class", a_mclass, 0);
        chk("short_sready", a_sready, 0);
        chk("short_feat", a_feat, FEAT_A);
        take();
        chk("short_cnt", a_cnt, 2);

        // good sample B after the error
        send9(smp_b);
        wait_valid(lat);
        chk("b_lat", lat, 2);
        chk("b_feat", a_feat, FEAT_B);
        chk("b_class", a_mclass, 2'd2);
        chk("b_err", a_merr, 0);
        take();
        chk("b_cnt", a_cnt, 3);

        // long sample: 12 beats, last on the 12th
        for (int i = 0; i < 12; i++) beat(8'h50 + 8'(i), i == 11);
        wait_valid(lat);
        chk("long_lat", lat, 1);
        chk("long_err", a_merr, 1);
        chk("long_class", a_mclass, 0);
        chk("long_feat", a_feat, FEAT_B);
        take();
        chk("long_cnt", a_cnt, 4);

        // reset mid-sample at idx=5, then a full sample
        for (int i = 0; i < 5; i++) beat(8'h60 + 8'(i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_mvalid", a_mvalid, 0);
        chk("midrst_cnt", a_cnt, 0);
        chk("midrst_feat", a_feat, 0);
        rst = 1'b0;
        send9(smp_c);
        wait_valid(lat);
        chk("c_lat", lat, 2);
        chk("c_feat", a_feat, FEAT_C);
        chk("c_class", a_mclass, 2'd3);
        take();
        repeat (3) @(negedge clk);
        chk("c_single_result", a_mvalid, 0);
        chk("c_cnt", a_cnt, 1);

        // CLS_LAT=3 instance with counter preloaded just below saturation
        @(negedge clk);
        use3 = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        force dut3.sample_cnt = 16'hFFFE;
        #1 release dut3.sample_cnt;
        send9(smp_a);
        wait_valid(lat);
        chk("l3_lat", lat, 5);
        chk("l3_class_a", a_mclass, 2'd1);
        take();
        chk("sat_cnt1", a_cnt, 16'hFFFF);
        send9(smp_b);
        wait_valid(lat);
        chk("l3_lat_b", lat, 5);
        chk("l3_class_b", a_mclass, 2'd2);
        take();
        chk("sat_cnt2", a_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dtree_feeder.md
DTREE_FEEDER -- requirements
Module: dtree_feeder

Interface
REQ-001 The block SHALL have parameter N_FEAT, default 9, meaning the number of features per sample.
REQ-002 The block SHALL have parameter FEAT_W, default 8, meaning the width of one feature in bits.
REQ-003 The block SHALL have parameter CLS_W, default 2, meaning the width of the classifier result.
REQ-004 The block SHALL have parameter CLS_LAT, default 0, meaning the classifier latency in clk cycles (0 = combinational).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 s_valid  input  1  feature byte valid.
REQ-008 s_ready  output  1  feeder accepts feature byte.
REQ-009 s_data  input  FEAT_W  feature value; sent in order X0 first, X(N_FEAT-1) last.
REQ-010 s_last  input  1  marks the final feature of a sample.
REQ-011 feat  output  N_FEAT*FEAT_W  assembled vector to classifier; X0 in bits [FEAT_W-1:0].
REQ-012 cls_in  input  CLS_W  classifier result for feat.
REQ-013 m_valid  output  1  result valid.
REQ-014 m_ready  input  1  downstream accepts result.
REQ-015 m_class  output  CLS_W  captured class.
REQ-016 m_err  output  1  sample was malformed; m_class is 0 and not meaningful.
REQ-017 sample_cnt  output  16  count of results accepted downstream, saturating at 0xFFFF.

Function
REQ-018 The FSM SHALL have states LOAD, DRAIN, EVAL, OUT.
REQ-019 In LOAD, s_ready SHALL be 1, and each s_valid&&s_ready beat SHALL write s_data into feature slot idx, then increment idx.
REQ-020 A beat with s_last=1 at idx==N_FEAT-1 SHALL complete the sample: go to EVAL, set the wait counter to CLS_LAT, and clear idx.
REQ-021 A beat with s_last=1 at idx<N_FEAT-1 SHALL set the error flag and go directly to OUT with m_err=1, m_class=0.
REQ-022 A beat at idx==N_FEAT-1 with s_last=0 SHALL set the error flag and go to DRAIN.
REQ-023 In DRAIN, s_ready SHALL be 1 and beats SHALL be discarded; the beat with s_last=1 SHALL move the FSM to OUT with m_err=1.
REQ-024 feat SHALL be driven from registers and remain stable from EVAL entry until the OUT handshake completes.
REQ-025 In EVAL, s_ready SHALL be 0 and the wait counter SHALL decrement each cycle; at 0, cls_in SHALL be registered into m_class and the FSM SHALL go to OUT.
REQ-026 With CLS_LAT=0, the latency from the last s_data beat to m_valid=1 SHALL be exactly 2 cycles: the EVAL cycle, then OUT.
REQ-027 In OUT, m_valid SHALL be 1, and m_class and m_err SHALL be held until m_valid&&m_ready.
REQ-028 On the OUT handshake, sample_cnt SHALL increment, saturating at 0xFFFF, and the FSM SHALL return to LOAD with s_ready=1 on the next cycle.
REQ-029 m_err results SHALL be counted in sample_cnt.
REQ-030 s_ready SHALL be 0 in EVAL and OUT; the input is never accepted while a result is pending.
REQ-031 Beats with s_valid=0 SHALL leave all state unchanged.

Reset
REQ-032 When rst=1 at a clk edge, the block SHALL enter LOAD.
REQ-033 Reset SHALL set idx=0, the error flag=0, feat=0, m_valid=0, m_class=0, m_err=0, and sample_cnt=0.
REQ-034 After reset, s_ready SHALL be 1 in the first cycle.
REQ-035 Reset in any state, including mid-sample or while holding a result, SHALL discard the partial sample or pending result without a handshake.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the default N_FEAT/FEAT_W/CLS_W constants, and the sample_cnt width.
REQ-037 The classifier SHALL stay external, connected only via feat/cls_in; the feeder has no sub-module.

Verification
REQ-038 Reset, then send 9 beats 0x10..0x18 with s_last on the 9th; hold m_ready=1 -> feat = 0x181716151413121110, m_valid is asserted 2 cycles after the last beat, m_class = cls_in, m_err=0, sample_cnt=1.
REQ-039 Send s_last on the 4th beat -> m_valid with m_err=1 and m_class=0; the next 9-beat sample is classified normally.
REQ-040 Send 12 beats with s_last only on the 12th -> beats 10-12 are accepted and dropped, then m_err=1; feat is unchanged from the prior good sample.
REQ-041 Hold m_ready=0 for 5 cycles in OUT -> s_ready=0, and m_valid, m_class and m_err are stable; on release, s_ready=1 on the next cycle.
REQ-042 Assert rst mid-sample at idx=5, then send a full sample -> only one result; idx restarts at X0, and sample_cnt=1.
REQ-043 Preload sample_cnt near 0xFFFF and run 2 samples -> sample_cnt stays at 0xFFFF; with CLS_LAT=3, m_valid is asserted 5 cycles after the last beat.
